uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
- Arbitrates round-robin and sequences uart_tx's tx_enable/tx_busy handshake, one byte at a time.
- Optional packet lock keeps multi-byte messages from one requester unbroken.
- Sits between client logic (debug ports, status reporters) and the single uart_tx instance driving the pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 16, max cycles from a tx_enable pulse to tx_busy rising before err_timeout is raised.
- LOCK_IDLE_MAX, 65535, cycles a locked requester may leave req_valid low before its lock is dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is last of packet; 0 requests lock.
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- tx_enable  out  1  to uart_tx; single-cycle start pulse.
- tx_data  out  8  to uart_tx; held stable from pulse until tx_busy falls.
- tx_busy  in  1  from uart_tx.
- grant_id  out  clog2(NUM_REQ)  index of current/last granted requester.
- locked  out  1  packet lock held by grant_id.
- err_timeout  out  1  sticky; tx_busy failed to rise in time.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: req_ready=0, tx_enable=0, tx_data=0, grant_id=0, locked=0, err_timeout=0. Round-robin pointer=0, so requester 0 has highest priority. State=ARB.
- FSM states: ARB, ISSUE, WAIT_START, WAIT_DONE.
- ARB:
  - Only when tx_busy=0.
  - If locked, only grant_id is eligible.
  - Otherwise the winner is the first requester with req_valid=1, searching from pointer upward with wrap-around.
  - On a winner: req_ready[w]=1 for that cycle (combinational from state). req_data[w] is captured into tx_data. grant_id<=w. pointer<=w+1 mod NUM_REQ. locked<=~req_last[w]. Go to ISSUE.
  - No eligible valid: stay in ARB, req_ready=0.
- ISSUE:
  - tx_enable=1 for exactly this one cycle; go to WAIT_START.
  - Latency: accept cycle to tx_enable is 1 cycle.
- WAIT_START:
  - Wait for tx_busy=1, then go to WAIT_DONE.
  - Cycle counter reaching START_TIMEOUT with tx_busy still 0: err_timeout<=1 (sticky until reset), locked<=0, go to ARB.
- WAIT_DONE:
  - Wait for tx_busy=0, then go to ARB.
  - Byte throughput per requester is bounded by the uart_tx frame time plus 3 cycles.
- Lock:
  - While locked and in ARB, a counter counts cycles with req_valid[grant_id]=0.
  - At LOCK_IDLE_MAX: locked<=0, counter cleared, and normal round-robin resumes in the same cycle.
  - The counter clears on every accept.
- Simultaneous events:
  - Several valids: exactly one req_ready bit is ever high.
  - A requester deasserting req_valid in the accept cycle is not accepted; the decision is taken on that cycle's valid.
- tx_busy=1 on entering ARB (uart still finishing a byte, e.g. after reset): no grant until it falls.
- Reset mid-operation:
  - FSM returns to ARB and tx_enable drops the next cycle.
  - A uart_tx frame already in flight completes on its own. The tx_busy gating above prevents any overlapping start.
- Arithmetic: pointer and grant_id wrap modulo NUM_REQ. Timeout counters saturate and do not wrap.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings ARB/ISSUE/WAIT_START/WAIT_DONE.
  - Byte width constant 8.
  - clog2 helper function.
- One natural sub-module: uart_rr_pick.
  - Combinational round-robin picker.
  - Inputs: request vector, pointer, lock enable, locked index.
  - Outputs: one-hot grant and winner index.
  - Reused later by the rx demux.

Test Plan:
- Req 1 sends 0xA5 with req_last=1, others idle -> req_ready[1] pulses once; tx_enable pulses 1 cycle later with tx_data=0xA5; grant_id=1; locked=0; next accept only after tx_busy falls.
- Reqs 0, 2 and 3 all continuously valid with req_last=1 -> accept order 0,2,3,0,2,3; never two req_ready bits high.
- Req 2 sends 0x10, 0x11 (req_last=0) then 0x12 (req_last=1) while req 0 is valid -> uart sees 10,11,12 contiguously, then req 0's byte; locked falls on the 0x12 accept.
- Req 3 locked (req_last=0), then goes idle; LOCK_IDLE_MAX=8 in bench -> after 8 idle ARB cycles locked=0 and waiting req 1 is granted.
- Stub tx_busy held at 0 -> err_timeout=1 START_TIMEOUT cycles after the tx_enable pulse; FSM back in ARB; err_timeout stays 1 until reset.
- Reset asserted during WAIT_DONE with tx_busy=1 -> all outputs at reset values next cycle; no tx_enable until tx_busy=0; first post-reset grant goes to requester 0 if it is valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbitration slice: FSM encoding, byte width
// and a constant-evaluable clog2 usable in parameter port lists.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with
// wrap-around, or only lock_idx while lock_en is high.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             lock_en,
    input  logic [IDX_W-1:0] lock_idx,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and a latch is never inferred.
    always_comb begin
        grant  = '0;
        winner = '0;
        if (lock_en) begin
            if (req[lock_idx]) begin
                grant[lock_idx] = 1'b1;
                winner          = lock_idx;
            end
        end else begin
            // Walk the ring backwards so the requester nearest ptr writes last and wins.
            for (int k = N - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % N]) begin
                    grant                      = '0;
                    grant[(int'(ptr) + k) % N] = 1'b1;
                    winner                     = IDX_W'((int'(ptr) + k) % N);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters: round-robin grant, one byte
// per tx_enable/tx_busy handshake, optional packet lock and start timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int START_TIMEOUT = 16,
    parameter  int LOCK_IDLE_MAX = 65535,
    localparam int IDX_W         = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_enable,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      locked,
    output logic                      err_timeout
);

    localparam int ST_W = clog2(START_TIMEOUT + 1);
    localparam int LK_W = clog2(LOCK_IDLE_MAX + 1);

    tx_state_e          state, state_next;
    logic [IDX_W-1:0]   ptr;
    logic [ST_W-1:0]    start_cnt;
    logic [LK_W-1:0]    lock_cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               lock_idle;
    logic               lock_expire;
    logic               start_expire;
    logic               accept;

    assign lock_idle    = locked && (state == ARB) && !req_valid[grant_id];
    // The idle cycle that reaches the limit already arbitrates unlocked.
    assign lock_expire  = lock_idle && (lock_cnt == LK_W'(LOCK_IDLE_MAX - 1));
    assign start_expire = (state == WAIT_START) && !tx_busy &&
                          (start_cnt >= ST_W'(START_TIMEOUT - 1));

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .lock_en  (locked && !lock_expire),
        .lock_idx (grant_id),
        .grant    (pick_grant),
        .winner   (pick_idx)
    );

    always_comb begin
        state_next = state;
        req_ready  = '0;
        tx_enable  = 1'b0;
        accept     = 1'b0;
        case (state)
            ARB: begin
                if (!reset && !tx_busy && (|pick_grant)) begin
                    req_ready  = pick_grant;
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tx_enable  = 1'b1;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy)           state_next = WAIT_DONE;
                else if (start_expire) state_next = ARB;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data     <= '0;
            grant_id    <= '0;
            ptr         <= '0;
            locked      <= 1'b0;
            lock_cnt    <= '0;
            start_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                tx_data  <= req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
                grant_id <= pick_idx;
                ptr      <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                locked   <= ~req_last[pick_idx];
                lock_cnt <= '0;
            end else if (lock_expire) begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else if (lock_idle && (lock_cnt != '1)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end

            if (state == ARB)          start_cnt <= '0;
            else if (start_cnt != '1) start_cnt <= start_cnt + 1'b1;

            if (start_expire) begin
                err_timeout <= 1'b1;
                locked      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester queues, a uart_tx stub and a scoreboard of
// expected accepts (requester, byte, last) compared as the DUT grants.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 10;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
    } acc_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_enable;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 locked;
    logic                 err_timeout;

    int total  = 0;
    int passed = 0;

    logic [8:0] rq [NUM_REQ][$];
    acc_t       exp_q[$];

    logic [NUM_REQ-1:0] pop_mask;
    logic       pend;
    int         pend_idx;
    logic [7:0] pend_data;
    logic       pend_lock;
    logic       dead;
    logic       stub_active;
    logic [7:0] stub_byte;
    int         stub_delay;
    int         stub_len;
    logic       busy_next;
    int         win;
    acc_t       e;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .START_TIMEOUT (16),
        .LOCK_IDLE_MAX (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = (rq[i].size() != 0);
            req_data[i*8 +: 8] = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]        = (rq[i].size() != 0) ? rq[i][0][8] : 1'b1;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        acc_t a;
        a.idx  = r;
        a.data = d;
        a.last = l;
        rq[r].push_back({l, d});
        exp_q.push_back(a);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stub_active || pend || tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(n < 500), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_accepts(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accepted"}, 32'(n < 200), 1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_seen"}, 32'(n < 100), 1);
    endtask

    // Requester, uart stub and scoreboard: sample at negedge, drive after posedge.
    initial begin : engine
        pend        = 1'b0;
        stub_active = 1'b0;
        stub_delay  = 0;
        stub_len    = 0;
        busy_next   = 1'b0;
        forever begin
            @(negedge clk);
            pop_mask = '0;
            if (pend) begin
                check("issue_latency", 32'(tx_enable), 1);
                check("tx_data", 32'(tx_data), 32'(pend_data));
                check("grant_id", 32'(grant_id), pend_idx);
                check("locked", 32'(locked), 32'(pend_lock));
                pend = 1'b0;
            end else if (tx_enable) begin
                check("enable_without_accept", 32'(tx_enable), 0);
            end

            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("accept_while_busy", 32'(stub_active), 0);
                win = -1;
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ready[i] && win < 0) win = i;
                if (exp_q.size() == 0 || rq[win].size() == 0) begin
                    check("unexpected_accept", win, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_idx", win, e.idx);
                    pop_mask[win] = 1'b1;
                    pend      = 1'b1;
                    pend_idx  = e.idx;
                    pend_data = e.data;
                    pend_lock = ~e.last;
                end
            end

            if (stub_active) begin
                if (stub_delay > 0) begin
                    stub_delay--;
                    if (stub_delay == 0) begin
                        busy_next = 1'b1;
                        stub_len  = FRAME;
                    end
                end else begin
                    stub_len--;
                    if (stub_len == 0) begin
                        busy_next   = 1'b0;
                        stub_active = 1'b0;
                        check("tx_data_hold", 32'(tx_data), 32'(stub_byte));
                    end
                end
            end
            if (tx_enable) begin
                check("overlapping_start", 32'(stub_active), 0);
                if (!dead) begin
                    stub_active = 1'b1;
                    stub_delay  = 2;
                    stub_byte   = tx_data;
                end
            end

            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (pop_mask[i]) void'(rq[i].pop_front());
            drive_reqs();
            tx_busy = busy_next;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int idle;
        reset     = 1'b1;
        dead      = 1'b0;
        tx_busy   = 1'b0;
        stub_byte = 8'h00;
        drive_reqs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_tx_enable", 32'(tx_enable), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);

        // Three requesters continuously valid: order 0,2,3,0,2,3.
        push(0, 8'h01, 1'b1); push(2, 8'h02, 1'b1); push(3, 8'h03, 1'b1);
        push(0, 8'h04, 1'b1); push(2, 8'h05, 1'b1); push(3, 8'h06, 1'b1);
        drain("rr");

        // Single byte from requester 1.
        push(1, 8'hA5, 1'b1);
        drain("single");

        // Locked packet from 2 holds off requester 0 despite the pointer.
        push(2, 8'h10, 1'b0); push(2, 8'h11, 1'b0); push(2, 8'h12, 1'b1);
        push(0, 8'h20, 1'b1);
        drain("packet");

        // Requester 3 locks then idles; requester 1 waits for lock expiry.
        push(3, 8'h30, 1'b0);
        wait_accepts("lock");
        push(1, 8'h31, 1'b1);
        wait_busy("lock");
        n    = 0;
        idle = 0;
        while (!req_ready[1] && n < 100) begin
            @(negedge clk);
            n++;
            if (!tx_busy) idle++;
        end
        // One WAIT_DONE cycle with tx_busy low, then the 8 idle ARB cycles.
        check("lock_idle_release", 32'(idle >= 9 && idle <= 10), 1);
        drain("lock");

        // Dead uart: start timeout, lock dropped, error sticky.
        dead = 1'b1;
        push(0, 8'h40, 1'b0);
        n = 0;
        while (!tx_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_unlock", 32'(locked), 0);
        dead = 1'b0;
        push(2, 8'h41, 1'b1);
        drain("after_timeout");
        check("err_sticky", 32'(err_timeout), 1);

        // Reset while the uart is mid-frame; pointer returns to 0.
        push(0, 8'h50, 1'b1);
        wait_accepts("pre_reset");
        wait_busy("pre_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        stub_byte = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
        push(0, 8'h51, 1'b1);
        push(1, 8'h52, 1'b1);
        @(negedge clk);
        check("mid_rst_busy", 32'(tx_busy), 1);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        check("mid_rst_tx_enable", 32'(tx_enable), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err_timeout", 32'(err_timeout), 0);
        drain("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
